// File: rtl/unified_mem_arbiter.sv
// Shares one async-read/sync-write word memory between the fetch and data ports.
// Single outstanding access with a fixed latency; ties alternate between ports.
module unified_mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_valid,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_d;
  logic             owner_d;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             req_write;
  logic             grant_i;
  logic             grant_d;

  // Grant decision: a lone requester always wins; a tie goes to the port not served last.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE && !reset) begin
      if (i_req && d_req) begin
        grant_d = !last_d;
        grant_i = last_d;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  assign i_ready   = grant_i;
  assign d_ready   = grant_d;
  assign mem_addr  = req_addr;
  assign mem_din   = req_wdata;
  assign mem_read  = (state == BUSY) && !req_write && !reset;
  assign mem_write = (state == BUSY) && (cnt == '0) && req_write && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_d    <= 1'b0;
      owner_d   <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_write <= 1'b0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_data    <= '0;
      d_rdata   <= '0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            // Fetches keep the previous write data; only stores need mem_din.
            req_addr  <= grant_d ? d_addr : i_addr;
            if (grant_d) req_wdata <= d_wdata;
            req_write <= grant_d && d_write;
            owner_d   <= grant_d;
            last_d    <= grant_d;
            cnt       <= CNT_LOAD;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (owner_d) begin
              d_valid <= 1'b1;
              if (!req_write) d_rdata <= mem_dout;
            end else begin
              i_valid <= 1'b1;
              i_data  <= mem_dout;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter against a transaction-level model
// that tracks acceptance cycle, response cycle and a shadow memory.
module tb_unified_mem_arbiter;

  localparam int unsigned LAT    = 4;
  localparam int          CYCLES = 3000;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_valid;
  logic [31:0] i_data;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  unified_mem_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid), .i_data(i_data),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write),
    .mem_dout(mem_dout)
  );

  // Memory attached to the DUT
  logic [31:0] mem [0:63];
  assign mem_dout = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_din;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [0:63];
  int          busy_end;
  logic        resp_pending;
  logic        owner_d;
  logic        cur_write;
  logic        last_d;
  logic [31:0] resp_data;
  logic [31:0] exp_i_data, exp_d_data, exp_addr, exp_din;
  logic        acc_i, acc_d;
  int          rst_stores;

  task automatic model_reset();
    busy_end     = -10;
    resp_pending = 1'b0;
    owner_d      = 1'b0;
    cur_write    = 1'b0;
    last_d       = 1'b0;
    resp_data    = '0;
    exp_i_data   = '0;
    exp_d_data   = '0;
    exp_addr     = '0;
    exp_din      = '0;
  endtask

  task automatic model_step();
    logic ev_i, ev_d, wi, wd, idle, busy;
    ev_i = 1'b0;
    ev_d = 1'b0;
    if (resp_pending && cyc == busy_end + 1) begin
      if (owner_d) begin
        ev_d = 1'b1;
        if (!cur_write) exp_d_data = resp_data;
      end else begin
        ev_i = 1'b1;
        exp_i_data = resp_data;
      end
      resp_pending = 1'b0;
    end
    idle = (cyc > busy_end);
    wi = 1'b0;
    wd = 1'b0;
    if (idle && !reset) begin
      if (i_req && d_req) begin
        wd = !last_d;
        wi = last_d;
      end else begin
        wi = i_req;
        wd = d_req;
      end
    end
    busy = !idle && !reset;
    check("i_ready",   32'(i_ready),   32'(wi));
    check("d_ready",   32'(d_ready),   32'(wd));
    check("mem_read",  32'(mem_read),  32'(busy && !cur_write));
    check("mem_write", 32'(mem_write), 32'(busy && cyc == busy_end && cur_write));
    check("i_valid",   32'(i_valid),   32'(ev_i));
    check("d_valid",   32'(d_valid),   32'(ev_d));
    check("i_data",    i_data,   exp_i_data);
    check("d_rdata",   d_rdata,  exp_d_data);
    check("mem_addr",  mem_addr, exp_addr);
    check("mem_din",   mem_din,  exp_din);
    if (reset) begin
      model_reset();
    end else begin
      if (busy && cyc == busy_end && cur_write) ref_mem[exp_addr[7:2]] = exp_din;
      if (wi || wd) begin
        exp_addr = wd ? d_addr : i_addr;
        if (wd) exp_din = d_wdata;
        cur_write    = wd && d_write;
        owner_d      = wd;
        last_d       = wd;
        busy_end     = cyc + int'(LAT);
        resp_pending = 1'b1;
        resp_data    = ref_mem[exp_addr[7:2]];
      end
    end
    acc_i = wi;
    acc_d = wd;
  endtask

  task automatic drive();
    reset = 1'b0;
    if (rst_stores < 3 && resp_pending && cur_write && cyc == busy_end) begin
      reset = 1'b1;
      rst_stores++;
    end else if ($urandom_range(0, 299) == 0) begin
      reset = 1'b1;
    end
    if (acc_i || (i_req && $urandom_range(0, 19) == 0)) begin
      i_req = 1'b0;
    end else if (!i_req && $urandom_range(0, 2) == 0) begin
      i_req  = 1'b1;
      i_addr = $urandom();
    end
    if (acc_d || (d_req && $urandom_range(0, 19) == 0)) begin
      d_req = 1'b0;
    end else if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req   = 1'b1;
      d_write = 1'($urandom_range(0, 1));
      d_addr  = $urandom();
      d_wdata = $urandom();
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      mem[k]     = $urandom();
      ref_mem[k] = mem[k];
    end
    model_reset();
    acc_i      = 1'b0;
    acc_d      = 1'b0;
    rst_stores = 0;
    reset      = 1'b1;
    i_req      = 1'b1;
    i_addr     = $urandom();
    d_req      = 1'b1;
    d_write    = 1'b0;
    d_addr     = $urandom();
    d_wdata    = $urandom();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst i_ready",   32'(i_ready),   32'd0);
    check("rst d_ready",   32'(d_ready),   32'd0);
    check("rst i_valid",   32'(i_valid),   32'd0);
    check("rst d_valid",   32'(d_valid),   32'd0);
    check("rst i_data",    i_data,         32'd0);
    check("rst d_rdata",   d_rdata,        32'd0);
    check("rst mem_addr",  mem_addr,       32'd0);
    check("rst mem_din",   mem_din,        32'd0);
    check("rst mem_read",  32'(mem_read),  32'd0);
    check("rst mem_write", 32'(mem_write), 32'd0);

    // Both ports request in the first cycle after reset: D must win the tie.
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    model_step();
    cyc++;
    for (int n = 0; n < CYCLES; n++) begin
      @(posedge clk);
      #1 drive();
      @(negedge clk);
      model_step();
      cyc++;
    end

    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 64; k++) check($sformatf("mem[%0d]", k), mem[k], ref_mem[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbiter and sequencer that shares one asynchronous-read, synchronous-write word memory between the instruction-fetch port and the data-access port of the multi-cycle CPU. It accepts one request at a time through a req/ready handshake and models a fixed memory access latency. It returns read data or a write acknowledgement through a one-cycle valid pulse. When both ports request in the same cycle, grants alternate so that neither port starves.

## Interface
- LATENCY, 4: cycles the memory is held busy per access; legal range 1..15.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction fetch request
- i_addr  in  32  fetch byte address
- i_ready  out  1  fetch request accepted this cycle
- i_valid  out  1  i_data valid; one-cycle pulse
- i_data  out  32  fetched word
- d_req  in  1  data request
- d_write  in  1  1 = store, 0 = load; qualified by d_req
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ready  out  1  data request accepted this cycle
- d_valid  out  1  load data valid or store done; one-cycle pulse
- d_rdata  out  32  loaded word
- mem_addr  out  32  address to memory (byte address; memory drops bits [1:0])
- mem_din  out  32  write data to memory
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable, sampled on the rising edge of clk
- mem_dout  in  32  asynchronous read data from memory

## Operation
- States: IDLE and BUSY. There is also a down-counter cnt (4 bits) and a register last_grant (I or D).
- IDLE:
  - If exactly one of i_req or d_req is high, that port is granted.
  - If both are high, the port not equal to last_grant is granted.
  - Only the granted port's ready is driven high, combinationally in the same cycle.
  - On the edge that ends the grant cycle:
    - Latch addr, wdata and write into the internal request registers. The write bit is 0 for a fetch.
    - Record the owner and set last_grant to the owner.
    - Load cnt with LATENCY-1 and go to BUSY.
- BUSY:
  - i_ready and d_ready are both 0.
  - mem_addr and mem_din come from the latched request registers.
  - mem_read equals the inverse of the latched write bit, for every BUSY cycle.
  - mem_write is 1 only in the BUSY cycle where cnt==0, and only for a store.
  - cnt decrements each cycle.
  - At cnt==0, on the edge that ends the cycle:
    - For a read, the owner's data register captures mem_dout.
    - The owner's valid is set for exactly one cycle, and the state returns to IDLE.
- The valid cycle is an IDLE cycle, so a new grant can happen in the same cycle that a response is delivered.
- Data registers hold their last value between responses. A store does not change d_rdata.
- In IDLE, mem_read and mem_write are 0 and mem_addr/mem_din hold their last latched values.
- Requesters must hold req, addr, wdata and write stable until ready is seen. A requester may drop req before ready; that request is then simply never granted.
- The arbiter is single-outstanding. No request is queued while BUSY.

## Timing
- Request accepted in cycle A (ready=1):
  - BUSY spans cycles A+1 to A+LATENCY.
  - valid=1 in cycle A+LATENCY+1.
  - A store commits on the edge that ends cycle A+LATENCY.
- Maximum throughput is one access per LATENCY+1 cycles.
- Reset values:
  - State IDLE, cnt=0, last_grant=I (so D wins the first tie).
  - i_valid, d_valid, i_data, d_rdata, mem_addr, mem_din, mem_read and mem_write are all 0.
- While reset is high, i_ready, d_ready, mem_read and mem_write are forced to 0.
- Reset asserted mid-access abandons the access:
  - No write occurs on the reset edge.
  - No valid is produced.
  - The next state is IDLE.
- LATENCY=1: BUSY lasts one cycle (cnt==0 immediately), and valid appears in A+2.
- Tie-break only matters when both requests are high in the same IDLE cycle. With a single requester, that requester always wins regardless of last_grant.

## Test plan
- Single load: memory word at 0x40 = 0xDEADBEEF, LATENCY=4. d_req, d_write=0, d_addr=0x40 in cycle 0 -> d_ready=1 in cycle 0, mem_read=1 in cycles 1-4, d_valid=1 with d_rdata=0xDEADBEEF in cycle 5 only.
- Contention: i_req and d_req held high from cycle 0 after reset -> grants in the order D, I, D, I. The valid pulses for those four accesses occur at cycles 5, 10, 15 and 20.
- Store then fetch: store 0x12345678 to address 0x8, then fetch address 0x8 -> mem_write=1 only in the final BUSY cycle of the store, d_valid at cycle 5, and i_data=0x12345678 on i_valid.
- Withdrawal: i_req raised during D's BUSY period and dropped before the arbiter returns to IDLE -> i_ready never asserted and no i_valid.
- Reset mid-store: reset asserted during the BUSY cycle with cnt==0 -> mem_write=0 on that edge, target word unchanged, no d_valid, all outputs at reset values in the next cycle.
- LATENCY=1 back-to-back loads from the same port -> accepts in cycles 0, 2, 4 and valids in cycles 2, 4, 6.
